mux8_74s151: RTL and testbench



---
 rtl/mux8_74s151.sv | 71 +++++++
 tb/tb_mux8_74s151.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mux8_74s151.sv
// 74S151 8-to-1 data selector with true (Q/Y) and complement (Q_N/W) outputs.
// The default build is combinational; OUT_REG=1 registers the outputs on clk.
module mux8_74s151 #(
  parameter int OUT_REG = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic I4,
  input  logic I5,
  input  logic I6,
  input  logic I7,
  input  logic SEL2,
  input  logic SEL1,
  input  logic SEL0,
  input  logic CE_N,
  output logic Q,
  output logic Q_N
);

  logic [2:0] idx;
  logic       data;
  logic       q_d;

  assign idx = {SEL2, SEL1, SEL0};

  // Unknown select or strobe values fall into the default arms, so X reaches the outputs.
  always_comb begin
    data = 1'bx;
    case (idx)
      3'd0:    data = I0;
      3'd1:    data = I1;
      3'd2:    data = I2;
      3'd3:    data = I3;
      3'd4:    data = I4;
      3'd5:    data = I5;
      3'd6:    data = I6;
      3'd7:    data = I7;
      default: data = 1'bx;
    endcase
    q_d = 1'bx;
    case (CE_N)
      1'b0:    q_d = data;
      1'b1:    q_d = 1'b0;
      default: q_d = 1'bx;
    endcase
  end

  if (OUT_REG != 0) begin : g_reg
    logic q_q;

    always_ff @(posedge clk) begin
      if (reset) q_q <= 1'b0;
      else       q_q <= q_d;
    end

    assign Q   = q_q;
    assign Q_N = ~q_q;
  end else begin : g_comb
    // clk and reset have no role in the combinational part.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    assign Q   = q_d;
    assign Q_N = ~q_d;
  end

endmodule

// File: tb/tb_mux8_74s151.sv
// Bench for mux8_74s151: one combinational and one registered instance share the same inputs.
module tb_mux8_74s151;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [2:0] sel;
  logic       ce_n;
  logic       q_c, qn_c, q_r, qn_r;

  int n_cmp  = 0;
  int n_fail = 0;

  logic exp_c[$];
  logic exp_r[$];

  always #5 clk = ~clk;

  mux8_74s151 #(.OUT_REG(0)) dut_c (
    .clk(clk), .reset(reset),
    .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]),
    .I4(din[4]), .I5(din[5]), .I6(din[6]), .I7(din[7]),
    .SEL2(sel[2]), .SEL1(sel[1]), .SEL0(sel[0]),
    .CE_N(ce_n), .Q(q_c), .Q_N(qn_c)
  );

  mux8_74s151 #(.OUT_REG(1)) dut_r (
    .clk(clk), .reset(reset),
    .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]),
    .I4(din[4]), .I5(din[5]), .I6(din[6]), .I7(din[7]),
    .SEL2(sel[2]), .SEL1(sel[1]), .SEL0(sel[0]),
    .CE_N(ce_n), .Q(q_r), .Q_N(qn_r)
  );

  function automatic logic model(input logic m_ce_n, input logic [2:0] m_sel, input logic [7:0] m_d);
    if (m_ce_n) return 1'b0;
    return m_d[m_sel];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (ce_n=%b sel=%0d din=%h reset=%b)",
             tag, obs, exp, ce_n, sel, din, reset);
    end
  endtask

  // Drive all inputs just after a falling edge and check the combinational outputs.
  task automatic apply(input logic a_ce_n, input logic [2:0] a_sel, input logic [7:0] a_d,
                       input logic a_rst, input string tag);
    logic e;
    @(negedge clk);
    ce_n  = a_ce_n;
    sel   = a_sel;
    din   = a_d;
    reset = a_rst;
    exp_c.push_back(model(a_ce_n, a_sel, a_d));
    #1;
    e = exp_c.pop_front();
    chk({tag, ".q"}, q_c, e);
    chk({tag, ".qn"}, qn_c, ~e);
  endtask

  // Predict the registered value from current inputs, then check it after the rising edge.
  task automatic reg_step(input string tag);
    logic e;
    exp_r.push_back(reset ? 1'b0 : model(ce_n, sel, din));
    @(posedge clk);
    #1;
    e = exp_r.pop_front();
    chk({tag, ".q"}, q_r, e);
    chk({tag, ".qn"}, qn_r, ~e);
  endtask

  // Registered outputs must still hold the given value before any further edge.
  task automatic reg_hold(input logic e, input string tag);
    exp_r.push_back(e);
    chk({tag, ".q"}, q_r, exp_r.pop_front());
    chk({tag, ".qn"}, qn_r, ~e);
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b1;
    ce_n  = 1'b1;
    sel   = 3'd0;
    din   = 8'h00;

    // Combinational: disabled, then data changing while disabled.
    apply(1'b1, 3'd0, 8'h00, 1'b1, "dis_zero");
    apply(1'b1, 3'd0, 8'h02, 1'b1, "dis_i1");

    for (int s = 0; s < 8; s++) apply(1'b0, 3'(s), 8'h02, 1'b1, "walk_i1");

    apply(1'b0, 3'd7, 8'h00, 1'b1, "top_lo");
    apply(1'b0, 3'd7, 8'h80, 1'b1, "top_hi");
    apply(1'b1, 3'd7, 8'h80, 1'b1, "top_dis");

    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 8; s++)
        for (int p = 0; p < 10; p++) begin
          pat = (p < 8) ? (8'h01 << p) : ((p == 8) ? 8'hFF : 8'h00);
          apply(c[0], 3'(s), pat, 1'b1, "exh");
        end

    // Registered: hold reset for two edges with a selected one.
    apply(1'b0, 3'd3, 8'h08, 1'b1, "r_setup");
    reg_step("r_rst1");
    reg_step("r_rst2");
    apply(1'b0, 3'd3, 8'h08, 1'b0, "r_rel");
    reg_hold(1'b0, "r_not_before");
    reg_step("r_load");
    apply(1'b0, 3'd2, 8'h08, 1'b0, "r_sel2");
    reg_hold(1'b1, "r_lat1");
    reg_step("r_sel2_edge");
    apply(1'b0, 3'd3, 8'h08, 1'b0, "r_sel3");
    reg_step("r_sel3_edge");

    // Reset overrides an enabled, selected one; then the value returns.
    apply(1'b0, 3'd3, 8'h08, 1'b1, "r_prec");
    reg_step("r_prec_edge");
    apply(1'b0, 3'd3, 8'h08, 1'b0, "r_prec_rel");
    reg_step("r_prec_back");
    apply(1'b1, 3'd3, 8'h08, 1'b0, "r_dis");
    reg_step("r_dis_edge");
    apply(1'b0, 3'd6, 8'h40, 1'b0, "r_i6");
    reg_step("r_i6_edge");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
